grid_shot_responder: RTL and testbench
======================================

# grid_shot_responder

Defender-side responder for enemy shots. It accepts a shot coordinate from the link/control logic and reads the player's own board memory, which holds 2-bit grid status codes. It then classifies the shot as hit or miss, writes the updated status back, and returns a response code. It also counts the remaining ship cells and raises a sticky `defeated` flag when none are left. It sits between the board RAM (written by the deployment logic) and the turn/game-state FSM.

## Interface
Parameters:
- `GRID_DIM`, 10: board edge length in cells; address = y*GRID_DIM + x.
- `SHIP_CELLS`, 10: ship cells on a fresh board (= SHIPS_NUMBER, single-cell ships).
- `ADDR_W`, 7: board memory address width.

Ports:
- `clk`, in, 1: system clock.
- `rst_n`, in, 1: synchronous active-low reset.
- `new_game`, in, 1: single-cycle pulse; restarts the block.
- `shot_valid`, in, 1: shot request present.
- `shot_ready`, out, 1: block can accept a shot.
- `shot_x`, in, 4: column.
- `shot_y`, in, 4: row.
- `resp_valid`, out, 1: response present.
- `resp_ready`, in, 1: consumer takes the response.
- `resp_code`, out, 2: 2'b10 MISS, 2'b11 HIT, 2'b00 invalid coordinate.
- `resp_repeat`, out, 1: target cell was already shot (no state change).
- `mem_addr`, out, ADDR_W: board RAM address.
- `mem_rd_data`, in, 2: RAM read data, valid 1 cycle after `mem_addr`.
- `mem_wr_en`, out, 1: write strobe.
- `mem_wr_data`, out, 2: write data.
- `ships_left`, out, 5: remaining ship cells.
- `defeated`, out, 1: sticky, set when `ships_left` reaches 0.

## Operation
- Grid codes: EMPTY 2'b00, MYSHIP 2'b01, MISS 2'b10, HIT 2'b11.
- FSM states: IDLE, READ, EVAL, RESP.
- IDLE:
  - `shot_ready` = !defeated.
  - On `shot_valid && shot_ready`, latch x and y.
  - If x or y >= GRID_DIM, go to RESP with code 2'b00; no memory access.
  - Otherwise go to READ.
- READ:
  - Drive `mem_addr` = y*GRID_DIM + x (registered, width-truncated to ADDR_W); go to EVAL.
- EVAL (`mem_rd_data` valid):
  - EMPTY: write MISS, code MISS.
  - MYSHIP: write HIT, code HIT, decrement `ships_left`. If it was 1, set `defeated`.
  - MISS or HIT: no write, code = stored value, `resp_repeat` = 1.
  - Go to RESP.
- RESP:
  - `resp_valid` = 1; code and repeat flag stay stable.
  - On `resp_ready`, go to IDLE.
- `mem_wr_en` is high only for the single EVAL cycle of an EMPTY or MYSHIP cell. `mem_addr` holds the READ address during that cycle.
- `ships_left` never decrements below 0, because a decrement happens only on a MYSHIP read.
- `new_game` has priority over every state:
  - next state IDLE;
  - `ships_left` <= SHIP_CELLS, `defeated` <= 0, `resp_valid` <= 0;
  - any in-flight write is suppressed in that cycle.

## Timing
- Reset (`rst_n` = 0 at a `clk` edge) sets:
  - state IDLE, `shot_ready` 1, `resp_valid` 0, `resp_code` 2'b00, `resp_repeat` 0;
  - `mem_addr` 0, `mem_wr_en` 0, `mem_wr_data` 0;
  - `ships_left` SHIP_CELLS, `defeated` 0.
- Accepted at edge T0 → `mem_addr` valid T1 → EVAL/write T2 → `resp_valid` high T3.
- An invalid coordinate gives `resp_valid` at T1.
- `resp_valid` is held until the edge at which `resp_ready` = 1.
- `shot_ready` rises on the cycle after the response handshake. Throughput is at most 1 shot per 4 cycles.
- `shot_ready` is low in READ, EVAL and RESP; a `shot_valid` there is ignored, not queued.
- `ships_left` and `defeated` update at the end of EVAL and are visible together with `resp_valid`.
- After `defeated`, `shot_ready` stays 0 until `new_game` or reset.

## Test plan
- Shot on a MYSHIP cell (x=3, y=2): after reset, preload addr 23 = 2'b01, shot (3,2) → write 2'b11 at addr 23 at T2; at T3 `resp_code` = 2'b11, repeat = 0, `ships_left` = 9.
- Shot on an EMPTY cell (0,0) → write 2'b10 at addr 0; `resp_code` 2'b10; `ships_left` unchanged.
- Repeat shot: shot (3,2) again → no `mem_wr_en`; `resp_code` 2'b11, `resp_repeat` = 1, `ships_left` still 9.
- Invalid coordinate (10,4) → no memory activity; `resp_valid` at T1 with code 2'b00.
- Defeat: with SHIP_CELLS = 2, hit both ship cells → `ships_left` 0, `defeated` 1, `shot_ready` stays 0. Then `new_game` → `ships_left` 2, `defeated` 0, `shot_ready` 1.
- Backpressure and abort:
  - Hold `resp_ready` = 0 for 5 cycles → response stable; `shot_ready` 0 throughout.
  - Pulse `new_game` during EVAL → no write, IDLE next cycle.
  - `rst_n` low mid-RESP → all outputs return to their reset values.

Source files
------------

// File: rtl/grid_shot_responder.sv
// Defender-side shot responder: reads the own-board cell for an incoming shot,
// marks it MISS/HIT, answers with a response code and tracks remaining ship cells.
module grid_shot_responder #(
    parameter int GRID_DIM   = 10,
    parameter int SHIP_CELLS = 10,
    parameter int ADDR_W     = 7
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              new_game,
    input  logic              shot_valid,
    output logic              shot_ready,
    input  logic [3:0]        shot_x,
    input  logic [3:0]        shot_y,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [1:0]        resp_code,
    output logic              resp_repeat,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [1:0]        mem_rd_data,
    output logic              mem_wr_en,
    output logic [1:0]        mem_wr_data,
    output logic [4:0]        ships_left,
    output logic              defeated
);

    typedef enum logic [1:0] {IDLE, READ, EVAL, RESP} state_t;

    localparam logic [1:0] CODE_INVALID = 2'b00;
    localparam logic [1:0] CELL_SHIP    = 2'b01;

    state_t            state;
    logic              coord_ok;
    logic [ADDR_W-1:0] shot_addr;
    logic [1:0]        marked_cell;

    assign coord_ok  = (int'(shot_x) < GRID_DIM) && (int'(shot_y) < GRID_DIM);
    assign shot_addr = ADDR_W'(int'(shot_y) * GRID_DIM + int'(shot_x));

    // EMPTY->MISS and MYSHIP->HIT, while MISS/HIT map onto themselves: the
    // outcome is always {1, low bit of the stored code}.
    assign marked_cell = {1'b1, mem_rd_data[0]};

    // NOTE: every signal assigned here gets a default first so no latch is inferred.
    // The strobe is combinational because the read data only arrives during EVAL;
    // new_game and reset kill it in the same cycle.
    always_comb begin
        mem_wr_en   = 1'b0;
        mem_wr_data = 2'b00;
        if (state == EVAL && rst_n && !new_game && !mem_rd_data[1]) begin
            mem_wr_en   = 1'b1;
            mem_wr_data = marked_cell;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            shot_ready  <= 1'b1;
            resp_valid  <= 1'b0;
            resp_code   <= CODE_INVALID;
            resp_repeat <= 1'b0;
            mem_addr    <= '0;
            ships_left  <= 5'(SHIP_CELLS);
            defeated    <= 1'b0;
        end else if (new_game) begin
            state      <= IDLE;
            shot_ready <= 1'b1;
            resp_valid <= 1'b0;
            ships_left <= 5'(SHIP_CELLS);
            defeated   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (shot_valid && shot_ready) begin
                        shot_ready  <= 1'b0;
                        resp_repeat <= 1'b0;
                        if (coord_ok) begin
                            // Address is issued on acceptance so the RAM data lands in EVAL.
                            mem_addr <= shot_addr;
                            state    <= READ;
                        end else begin
                            resp_code  <= CODE_INVALID;
                            resp_valid <= 1'b1;
                            state      <= RESP;
                        end
                    end
                end
                READ: begin
                    state <= EVAL;
                end
                EVAL: begin
                    resp_code   <= marked_cell;
                    resp_repeat <= mem_rd_data[1];
                    if (mem_rd_data == CELL_SHIP && ships_left != 5'd0) begin
                        ships_left <= ships_left - 5'd1;
                        if (ships_left == 5'd1) begin
                            defeated <= 1'b1;
                        end
                    end
                    resp_valid <= 1'b1;
                    state      <= RESP;
                end
                RESP: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        shot_ready <= !defeated;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_grid_shot_responder.sv
// Bench for grid_shot_responder: board RAM model, directed vector table,
// hand-written abort/backpressure/defeat sequences and randomized games vs a model.
module tb_grid_shot_responder;

    localparam int GRID  = 10;
    localparam int SHIPS = 10;

    logic       clk = 1'b0;
    logic       rst_n, new_game, shot_valid, shot_ready;
    logic [3:0] shot_x, shot_y;
    logic       resp_valid, resp_ready, resp_repeat;
    logic [1:0] resp_code;
    logic [6:0] mem_addr;
    logic [1:0] mem_rd_data, mem_wr_data;
    logic       mem_wr_en;
    logic [4:0] ships_left;
    logic       defeated;

    grid_shot_responder #(.GRID_DIM(GRID), .SHIP_CELLS(SHIPS), .ADDR_W(7)) dut (
        .clk(clk), .rst_n(rst_n), .new_game(new_game),
        .shot_valid(shot_valid), .shot_ready(shot_ready),
        .shot_x(shot_x), .shot_y(shot_y),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_code(resp_code), .resp_repeat(resp_repeat),
        .mem_addr(mem_addr), .mem_rd_data(mem_rd_data),
        .mem_wr_en(mem_wr_en), .mem_wr_data(mem_wr_data),
        .ships_left(ships_left), .defeated(defeated)
    );

    always #5 clk = ~clk;

    // Board RAM: synchronous read (data one cycle after the address), write on strobe.
    logic [1:0] ram [0:127];
    logic       clr, pl_en;
    logic [6:0] pl_addr;
    logic [1:0] pl_data;
    int         wr_count = 0;
    logic [6:0] last_wr_addr;
    logic [1:0] last_wr_data;

    always @(posedge clk) begin
        if (clr) begin
            for (int i = 0; i < 128; i++) ram[i] <= 2'b00;
        end else if (pl_en) begin
            ram[pl_addr] <= pl_data;
        end
        if (mem_wr_en) begin
            ram[mem_addr] <= mem_wr_data;
            wr_count      <= wr_count + 1;
            last_wr_addr  <= mem_addr;
            last_wr_data  <= mem_wr_data;
        end
        mem_rd_data <= ram[mem_addr];
    end

    int checks = 0;
    int errors = 0;

    // Reference model: board contents and ship count at transaction level.
    logic [1:0] board_m [0:99];
    int         ships_m;
    logic       def_m;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic model_shot(input int x, input int y,
                              output logic [1:0] code, output logic rep, output logic wr);
        int a;
        code = 2'b00; rep = 1'b0; wr = 1'b0;
        if (x < GRID && y < GRID) begin
            a = y * GRID + x;
            case (board_m[a])
                2'b00: begin code = 2'b10; board_m[a] = 2'b10; wr = 1'b1; end
                2'b01: begin
                    code = 2'b11; board_m[a] = 2'b11; wr = 1'b1;
                    if (ships_m > 0) ships_m--;
                    if (ships_m == 0) def_m = 1'b1;
                end
                default: begin code = board_m[a]; rep = 1'b1; end
            endcase
        end
    endtask

    task automatic clear_board();
        clr = 1'b1; step(); clr = 1'b0;
        for (int i = 0; i < 100; i++) board_m[i] = 2'b00;
    endtask

    task automatic place(input int addr, input logic [1:0] val);
        pl_en = 1'b1; pl_addr = 7'(addr); pl_data = val;
        step();
        pl_en = 1'b0;
        board_m[addr] = val;
    endtask

    task automatic pulse_new_game();
        new_game = 1'b1; step(); new_game = 1'b0;
        ships_m = SHIPS; def_m = 1'b0;
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_shot_ready"},  32'(shot_ready),  32'd1);
        check({tag, "_resp_valid"},  32'(resp_valid),  32'd0);
        check({tag, "_resp_code"},   32'(resp_code),   32'd0);
        check({tag, "_resp_repeat"}, 32'(resp_repeat), 32'd0);
        check({tag, "_mem_addr"},    32'(mem_addr),    32'd0);
        check({tag, "_mem_wr_en"},   32'(mem_wr_en),   32'd0);
        check({tag, "_mem_wr_data"}, 32'(mem_wr_data), 32'd0);
        check({tag, "_ships_left"},  32'(ships_left),  32'(SHIPS));
        check({tag, "_defeated"},    32'(defeated),    32'd0);
    endtask

    task automatic wait_ready(input string tag);
        int n = 0;
        while (!shot_ready && n < 20) begin step(); n++; end
        check({tag, "_ready_wait"}, 32'(shot_ready), 32'd1);
    endtask

    // One complete shot transaction with expected results supplied by the caller.
    task automatic shoot(input string tag, input int x, input int y,
                         input logic [1:0] ec, input logic er, input int es,
                         input logic ed, input logic ew, input int hold);
        int wc0, lat;
        logic [1:0] held_code;
        wait_ready(tag);
        wc0 = wr_count;
        shot_x = 4'(x); shot_y = 4'(y); shot_valid = 1'b1;
        step();
        shot_valid = 1'b0;
        lat = 0;
        while (!resp_valid && lat < 10) begin step(); lat++; end
        check({tag, "_resp_valid"}, 32'(resp_valid), 32'd1);
        check({tag, "_latency"}, 32'(lat), (ec == 2'b00) ? 32'd0 : 32'd2);
        check({tag, "_code"}, 32'(resp_code), 32'(ec));
        check({tag, "_repeat"}, 32'(resp_repeat), 32'(er));
        check({tag, "_ships"}, 32'(ships_left), 32'(es));
        check({tag, "_defeated"}, 32'(defeated), 32'(ed));
        check({tag, "_writes"}, 32'(wr_count - wc0), 32'(ew));
        if (ew) begin
            check({tag, "_wr_addr"}, 32'(last_wr_addr), 32'(y * GRID + x));
            check({tag, "_wr_data"}, 32'(last_wr_data), 32'(ec));
        end
        held_code = resp_code;
        for (int i = 0; i < hold; i++) begin
            shot_valid = 1'b1;
            step();
            check({tag, "_hold_valid"}, 32'(resp_valid), 32'd1);
            check({tag, "_hold_code"}, 32'(resp_code), 32'(held_code));
            check({tag, "_hold_ready"}, 32'(shot_ready), 32'd0);
        end
        shot_valid = 1'b0;
        resp_ready = 1'b1;
        step();
        resp_ready = 1'b0;
        check({tag, "_resp_done"}, 32'(resp_valid), 32'd0);
        check({tag, "_ready_after"}, 32'(shot_ready), 32'(!ed));
        check({tag, "_no_extra_wr"}, 32'(wr_count - wc0), 32'(ew));
    endtask

    typedef struct {
        int         x;
        int         y;
        logic [1:0] code;
        logic       rep;
        int         ships;
        logic       wr;
        int         hold;
    } vec_t;

    vec_t vecs [10];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [1:0] mc;
        logic       mr, mw;
        int         wc0, x, y, a, placed, shots;

        vecs[0] = '{3, 2, 2'b11, 1'b0, 9, 1'b1, 0};
        vecs[1] = '{0, 0, 2'b10, 1'b0, 9, 1'b1, 0};
        vecs[2] = '{3, 2, 2'b11, 1'b1, 9, 1'b0, 5};
        vecs[3] = '{10, 4, 2'b00, 1'b0, 9, 1'b0, 0};
        vecs[4] = '{0, 0, 2'b10, 1'b1, 9, 1'b0, 0};
        vecs[5] = '{5, 5, 2'b11, 1'b0, 8, 1'b1, 2};
        vecs[6] = '{9, 9, 2'b10, 1'b0, 8, 1'b1, 0};
        vecs[7] = '{4, 15, 2'b00, 1'b0, 8, 1'b0, 0};
        vecs[8] = '{15, 15, 2'b00, 1'b0, 8, 1'b0, 1};
        vecs[9] = '{5, 5, 2'b11, 1'b1, 8, 1'b0, 0};

        rst_n = 1'b0; new_game = 1'b0; shot_valid = 1'b0; resp_ready = 1'b0;
        shot_x = '0; shot_y = '0; clr = 1'b0; pl_en = 1'b0; pl_addr = '0; pl_data = '0;
        ships_m = SHIPS; def_m = 1'b0;
        step();
        clear_board();
        step();
        check_reset_state("reset");
        rst_n = 1'b1;
        step();

        // Directed vectors on a board with ships at (3,2), (5,5), (7,1).
        place(23, 2'b01);
        place(55, 2'b01);
        place(17, 2'b01);
        for (int i = 0; i < 10; i++) begin
            model_shot(vecs[i].x, vecs[i].y, mc, mr, mw);
            shoot($sformatf("vec%0d", i), vecs[i].x, vecs[i].y, vecs[i].code,
                  vecs[i].rep, vecs[i].ships, 1'b0, vecs[i].wr, vecs[i].hold);
        end

        // new_game during EVAL must cancel the pending HIT write at (7,1).
        wait_ready("abort");
        wc0 = wr_count;
        shot_x = 4'd7; shot_y = 4'd1; shot_valid = 1'b1;
        step();
        shot_valid = 1'b0;
        step();
        check("abort_wr_pending", 32'(mem_wr_en), 32'd1);
        new_game = 1'b1;
        #1;
        check("abort_wr_killed", 32'(mem_wr_en), 32'd0);
        step();
        new_game = 1'b0;
        ships_m = SHIPS; def_m = 1'b0;
        check("abort_resp_valid", 32'(resp_valid), 32'd0);
        check("abort_shot_ready", 32'(shot_ready), 32'd1);
        check("abort_ships", 32'(ships_left), 32'(SHIPS));
        check("abort_writes", 32'(wr_count - wc0), 32'd0);
        check("abort_cell_kept", 32'(ram[17]), 32'd1);
        step();
        check("abort_stays_idle", 32'(resp_valid), 32'd0);

        // Reset while a response is being held.
        wait_ready("rstresp");
        model_shot(2, 8, mc, mr, mw);
        shot_x = 4'd2; shot_y = 4'd8; shot_valid = 1'b1;
        step();
        shot_valid = 1'b0;
        for (int n = 0; n < 10 && !resp_valid; n++) step();
        check("rstresp_valid", 32'(resp_valid), 32'd1);
        check("rstresp_code", 32'(resp_code), 32'(mc));
        rst_n = 1'b0;
        step();
        check_reset_state("rstresp");
        rst_n = 1'b1;
        ships_m = SHIPS; def_m = 1'b0;
        step();

        // Defeat: sink every ship on the diagonal.
        clear_board();
        pulse_new_game();
        for (int k = 0; k < SHIPS; k++) place(k * 11, 2'b01);
        for (int k = 0; k < SHIPS; k++) begin
            model_shot(k, k, mc, mr, mw);
            shoot($sformatf("sink%0d", k), k, k, mc, mr, ships_m, def_m, mw, 0);
        end
        check("defeat_ships", 32'(ships_left), 32'd0);
        check("defeat_flag", 32'(defeated), 32'd1);
        shot_x = 4'd1; shot_y = 4'd2; shot_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("defeat_ready_low", 32'(shot_ready), 32'd0);
            check("defeat_no_resp", 32'(resp_valid), 32'd0);
        end
        shot_valid = 1'b0;
        pulse_new_game();
        check("newgame_ships", 32'(ships_left), 32'(SHIPS));
        check("newgame_defeated", 32'(defeated), 32'd0);
        check("newgame_ready", 32'(shot_ready), 32'd1);

        // Randomized games against the model, including off-board coordinates.
        for (int g = 0; g < 3; g++) begin
            clear_board();
            pulse_new_game();
            placed = 0;
            while (placed < SHIPS) begin
                a = $urandom_range(0, 99);
                if (board_m[a] == 2'b00) begin
                    place(a, 2'b01);
                    placed++;
                end
            end
            shots = 0;
            while (!def_m && shots < 120) begin
                x = $urandom_range(0, 11);
                y = $urandom_range(0, 11);
                model_shot(x, y, mc, mr, mw);
                shoot($sformatf("rnd%0d_%0d", g, shots), x, y, mc, mr, ships_m, def_m, mw,
                      $urandom_range(0, 2));
                shots++;
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
